// File: rtl/jtframe_pocket_bridge.sv
// Core-side target for the Analogue Pocket bridge SPI link.
// Deserialises 2-bit-wide commands into a parallel register bus and serialises read data back.
module jtframe_pocket_bridge #(
    parameter int DIV     = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spiss,
    input  logic        spiclk_in,
    input  logic        mosi_in,
    input  logic        miso_in,
    output logic        spiclk_out,
    output logic        spiclk_oe,
    output logic [1:0]  dout,
    output logic        dout_oe,
    output logic [31:0] bus_addr,
    output logic        bus_wr,
    output logic        bus_rd,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        busy,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DW = $clog2(DIV);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_WWAIT, S_RREQ, S_RWAIT, S_RDATA, S_DONE
    } state_t;

    state_t state, nxt;

    logic [1:0]    ss_sync, ck_sync, mo_sync, mi_sync;
    logic          ss_d, ck_d;
    logic          ss_s, ck_s, mo_s, mi_s;
    logic          sample, ss_fall, last_pair, tout, ph_end, rd_last;
    logic [29:0]   shreg;
    logic [31:0]   word, rd_word;
    logic [3:0]    cnt, bit_cnt;
    logic [TW-1:0] tcnt;
    logic [DW-1:0] ph_cnt;
    logic          ph_hi;
    logic [29:0]   rshift;

    assign ss_s      = ss_sync[1];
    assign ck_s      = ck_sync[1];
    assign mo_s      = mo_sync[1];
    assign mi_s      = mi_sync[1];
    assign sample    = ck_s & ~ck_d;
    assign ss_fall   = ss_d & ~ss_s;
    assign word      = {shreg, mo_s, mi_s};
    assign last_pair = sample && (cnt == 4'd15);
    assign tout      = (state == S_WWAIT || state == S_RWAIT) && (tcnt == TW'(TIMEOUT)) && !bus_ack;
    assign ph_end    = (ph_cnt == DW'(DIV - 1));
    assign rd_last   = ph_hi && ph_end && (bit_cnt == 4'd15);
    assign rd_word   = bus_ack ? bus_rdata : 32'hDEAD_BEEF;
    assign busy      = (state != S_IDLE);

    // Select idles high so a reset never looks like the start of a transaction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_sync <= 2'b11;
            ck_sync <= 2'b00;
            mo_sync <= 2'b00;
            mi_sync <= 2'b00;
            ss_d    <= 1'b1;
            ck_d    <= 1'b0;
        end else begin
            ss_sync <= {ss_sync[0], spiss};
            ck_sync <= {ck_sync[0], spiclk_in};
            mo_sync <= {mo_sync[0], mosi_in};
            mi_sync <= {mi_sync[0], miso_in};
            ss_d    <= ss_s;
            ck_d    <= ck_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (!ss_s) nxt = S_ADDR;
            S_ADDR: begin
                if (ss_s)           nxt = S_IDLE;
                else if (last_pair) nxt = mi_s ? S_WDATA : S_RREQ;
            end
            S_WDATA: begin
                if (ss_s)           nxt = S_IDLE;
                else if (last_pair) nxt = S_WWAIT;
            end
            S_WWAIT: if (bus_ack || tout) nxt = ss_s ? S_IDLE : S_DONE;
            S_RREQ:  nxt = bus_ack ? (ss_s ? S_IDLE : S_RDATA) : S_RWAIT;
            // A host that deselected during the wait gets no read data back
            S_RWAIT: if (bus_ack || tout) nxt = ss_s ? S_IDLE : S_RDATA;
            S_RDATA: begin
                if (ss_s)         nxt = S_IDLE;
                else if (rd_last) nxt = S_DONE;
            end
            S_DONE:  if (ss_s) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_wr     <= 1'b0;
            bus_rd     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            err        <= 1'b0;
            tcnt       <= '0;
            shreg      <= '0;
            cnt        <= '0;
            rshift     <= '0;
            dout       <= '0;
            spiclk_out <= 1'b0;
            spiclk_oe  <= 1'b0;
            dout_oe    <= 1'b0;
            ph_cnt     <= '0;
            ph_hi      <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            bus_wr <= (state == S_WDATA) && !ss_s && last_pair;
            bus_rd <= (state == S_ADDR) && !ss_s && last_pair && !mi_s;
            if (tout)         err <= 1'b1;
            else if (ss_fall) err <= 1'b0;
            tcnt <= (state == S_WWAIT || state == S_RWAIT) ? tcnt + TW'(1) : '0;

            // The 4-bit counter wraps to zero on the 16th event, which starts the data word cleanly
            if (state == S_IDLE) begin
                shreg <= '0;
                cnt   <= '0;
            end else if ((state == S_ADDR || state == S_WDATA) && sample) begin
                shreg <= word[29:0];
                cnt   <= cnt + 4'd1;
                if (cnt == 4'd15 && !ss_s) begin
                    if (state == S_ADDR) bus_addr  <= {word[31:1], 1'b0};
                    else                 bus_wdata <= word;
                end
            end

            if (state != S_RDATA && nxt == S_RDATA) begin
                rshift     <= rd_word[29:0];
                dout       <= rd_word[31:30];
                spiclk_out <= 1'b0;
                spiclk_oe  <= 1'b1;
                dout_oe    <= 1'b1;
                ph_cnt     <= '0;
                ph_hi      <= 1'b0;
                bit_cnt    <= '0;
            end else if (state == S_RDATA) begin
                if (nxt != S_RDATA) begin
                    spiclk_out <= 1'b0;
                    spiclk_oe  <= 1'b0;
                    dout_oe    <= 1'b0;
                    dout       <= '0;
                end else if (ph_end) begin
                    ph_cnt <= '0;
                    if (!ph_hi) begin
                        ph_hi      <= 1'b1;
                        spiclk_out <= 1'b1;
                    end else begin
                        ph_hi      <= 1'b0;
                        spiclk_out <= 1'b0;
                        bit_cnt    <= bit_cnt + 4'd1;
                        dout       <= rshift[29:28];
                        rshift     <= {rshift[27:0], 2'b00};
                    end
                end else begin
                    ph_cnt <= ph_cnt + DW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_jtframe_pocket_bridge.sv
// Scoreboard bench for jtframe_pocket_bridge: host tasks push expected bus strobes and
// read returns, a monitor pops and compares them as the DUT presents them.
module tb_jtframe_pocket_bridge;

    localparam int DIV     = 4;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spiss = 1'b1;
    logic        spiclk_in = 1'b0;
    logic        mosi_in = 1'b0;
    logic        miso_in = 1'b0;
    logic        spiclk_out, spiclk_oe, dout_oe;
    logic [1:0]  dout;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_wr, bus_rd;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        busy, err;

    jtframe_pocket_bridge #(.DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .spiss(spiss), .spiclk_in(spiclk_in),
        .mosi_in(mosi_in), .miso_in(miso_in), .spiclk_out(spiclk_out),
        .spiclk_oe(spiclk_oe), .dout(dout), .dout_oe(dout_oe),
        .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic        ack_enable = 1'b1;
    int          ack_delay = 3;
    logic [31:0] resp_data = '0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Host drives data during the low phase and raises the clock after half cycles
    task automatic send_pairs(input logic [31:0] w, input int n, input int half);
        for (int i = 15; i > 15 - n; i--) begin
            mosi_in = w[2*i+1];
            miso_in = w[2*i];
            wait_cycles(half);
            spiclk_in = 1'b1;
            wait_cycles(half);
            spiclk_in = 1'b0;
        end
    endtask

    task automatic apply_write(input logic [31:0] addr, input logic [31:0] data, input int half);
        sb.push_back('{0, {addr[31:1], 1'b0}, data});
        ack_enable = 1'b1;
        ack_delay  = 3;
        spiss = 1'b0;
        wait_cycles(4);
        send_pairs(addr, 16, half);
        send_pairs(data, 16, half);
        wait_cycles(20);
        check_output("wr_err", err, 0);
        check_output("wr_busy_done", busy, 1);
        spiss = 1'b1;
        wait_cycles(5);
        check_output("wr_busy_idle", busy, 0);
        check_output("wr_addr_hold", bus_addr, {addr[31:1], 1'b0});
        check_output("wr_data_hold", bus_wdata, data);
    endtask

    task automatic apply_read(input logic [31:0] addr, input logic [31:0] resp, input logic ack_en,
                              input logic [31:0] exp_data, input logic exp_err);
        int n;
        sb.push_back('{1, {addr[31:1], 1'b0}, 32'h0});
        sb.push_back('{2, 32'h0, exp_data});
        ack_enable = ack_en;
        ack_delay  = 5;
        resp_data  = resp;
        spiss = 1'b0;
        wait_cycles(4);
        send_pairs(addr, 16, 4);
        n = 0;
        while (!spiclk_oe && n < 600) begin
            wait_cycles(1);
            n++;
        end
        check_output("rd_oe_start", spiclk_oe, 1);
        check_output("rd_dout_oe_start", dout_oe, 1);
        check_output("rd_err", err, exp_err);
        n = 0;
        while (spiclk_oe && n < 300) begin
            wait_cycles(1);
            n++;
        end
        check_output("rd_return_cycles", n, 16 * 2 * DIV);
        check_output("rd_oe_released", dout_oe, 0);
        check_output("rd_clk_low", spiclk_out, 0);
        spiss = 1'b1;
        wait_cycles(5);
        check_output("rd_busy_idle", busy, 0);
        check_output("rd_err_held", err, exp_err);
    endtask

    // Bus slave: acks each strobe after ack_delay cycles when enabled
    initial begin
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if ((bus_wr || bus_rd) && ack_enable) begin
                repeat (ack_delay) @(posedge clk);
                #1;
                bus_ack   = 1'b1;
                bus_rdata = resp_data;
                @(posedge clk);
                #1;
                bus_ack   = 1'b0;
                bus_rdata = '0;
            end
        end
    end

    // Monitor: compares strobes and each completed 16-pair read return against the scoreboard
    logic        prev_sck = 1'b0;
    logic [31:0] rx = '0;
    int          nrx = 0;
    exp_t        e;

    always @(negedge clk) begin
        if (bus_wr) begin
            check_output("wr_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_output("wr_kind", e.kind, 0);
                check_output("wr_addr", bus_addr, e.addr);
                check_output("wr_data", bus_wdata, e.data);
            end
        end
        if (bus_rd) begin
            check_output("rd_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_output("rd_kind", e.kind, 1);
                check_output("rd_addr", bus_addr, e.addr);
            end
        end
        if (!spiclk_oe) begin
            nrx = 0;
        end else if (spiclk_out && !prev_sck) begin
            rx = {rx[29:0], dout};
            nrx++;
            if (nrx == 16) begin
                nrx = 0;
                check_output("ret_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_output("ret_kind", e.kind, 2);
                    check_output("ret_data", rx, e.data);
                end
            end
        end
        prev_sck = spiclk_out;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        wait_cycles(3);
        check_output("rst_busy", busy, 0);
        check_output("rst_err", err, 0);
        check_output("rst_spiclk_oe", spiclk_oe, 0);
        check_output("rst_dout_oe", dout_oe, 0);
        check_output("rst_spiclk_out", spiclk_out, 0);
        check_output("rst_dout", dout, 0);
        check_output("rst_bus_addr", bus_addr, 0);
        check_output("rst_bus_wdata", bus_wdata, 0);
        check_output("rst_strobes", {bus_wr, bus_rd}, 0);
        rst_n = 1'b1;
        wait_cycles(3);

        $display("[TB] write command");
        apply_write(32'hF800_0001, 32'h1234_5678, 4);

        $display("[TB] read command");
        apply_read(32'hF800_0000, 32'hCAFE_0042, 1'b1, 32'hCAFE_0042, 1'b0);

        $display("[TB] read timeout");
        apply_read(32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        spiss = 1'b0;
        wait_cycles(4);
        check_output("err_cleared", err, 0);
        spiss = 1'b1;
        wait_cycles(5);

        $display("[TB] abort during address");
        spiss = 1'b0;
        wait_cycles(4);
        send_pairs(32'hF800_0001, 10, 4);
        spiss = 1'b1;
        wait_cycles(4);
        check_output("abort_busy", busy, 0);
        apply_write(32'hA5A5_0003, 32'h0BAD_F00D, 4);

        $display("[TB] reset during read return");
        sb.push_back('{1, 32'h0000_0100, 32'h0});
        ack_enable = 1'b1;
        ack_delay  = 2;
        resp_data  = 32'h5555_AAAA;
        spiss = 1'b0;
        wait_cycles(4);
        send_pairs(32'h0000_0100, 16, 4);
        n = 0;
        while (!spiclk_oe && n < 100) begin
            wait_cycles(1);
            n++;
        end
        check_output("rst_mid_oe_seen", spiclk_oe, 1);
        wait_cycles(20);
        rst_n = 1'b0;
        wait_cycles(1);
        rst_n = 1'b1;
        check_output("rst_mid_spiclk_oe", spiclk_oe, 0);
        check_output("rst_mid_dout_oe", dout_oe, 0);
        check_output("rst_mid_busy", busy, 0);
        wait_cycles(10);
        spiss = 1'b1;
        wait_cycles(6);
        check_output("rst_mid_idle", busy, 0);

        $display("[TB] slow host write");
        apply_write(32'h0000_1235, 32'hDEAD_0001, 3);

        wait_cycles(10);
        check_output("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtframe_pocket_bridge.md
# jtframe_pocket_bridge

Core-side target for the Analogue Pocket bridge SPI link; it sits directly downstream of the host SPI master on `brg_spiss`/`brg_spiclk`/`brg_spimosi`/`brg_spimiso`. It oversamples the 2-bit-wide serial link on the core clock and deserialises 64-bit write commands or 32-bit read addresses. Each command becomes one access on a simple parallel register bus. For reads, the block drives the link's clock and both data lines itself to return 32 bits.

## Interface

- `DIV`, 4: half-period of the target-sourced SPI clock during read return, in `clk` cycles (≥2).
- `TIMEOUT`, 255: maximum `clk` cycles to wait for `bus_ack` before an error is flagged.

- `clk` in 1: core clock; all logic is on its rising edge.
- `rst_n` in 1: reset; synchronous and active-low.
- `spiss` in 1: bridge select, active-low, asynchronous to `clk`.
- `spiclk_in` in 1: bridge clock from the host.
- `mosi_in` in 1: serial data line, odd bits (MSB of each pair).
- `miso_in` in 1: serial data line, even bits (LSB of each pair).
- `spiclk_out` out 1: target-sourced clock during read return.
- `spiclk_oe` out 1: drive enable for `spiclk_out`.
- `dout` out 2: read data; `dout[1]` goes to mosi and `dout[0]` to miso.
- `dout_oe` out 1: drive enable for both data lines.
- `bus_addr` out 32: `{addr[31:1],1'b0}`.
- `bus_wr` out 1: single-cycle write strobe.
- `bus_rd` out 1: single-cycle read strobe.
- `bus_wdata` out 32: write data.
- `bus_rdata` in 32: read data, valid when `bus_ack`=1.
- `bus_ack` in 1: access complete (single-cycle pulse).
- `busy` out 1: high whenever state ≠ IDLE.
- `err` out 1: sticky; set by a timeout, cleared by the next falling edge of `spiss`.

## Operation

Synchronisation
- `spiss`, `spiclk_in`, `mosi_in` and `miso_in` each pass through a 2-flop synchroniser.
- A rising edge of the synchronised `spiclk_in` is a sample event; it captures `{mosi,miso}` into a shift register, MSB first.

Word format
- Address word: 32 bits in 16 sample events. Bit 0 is the direction flag: 1 = write, 0 = read.
- Write data word: 32 bits in 16 further sample events.

State machine
- IDLE: waits for the synchronised `spiss` to go low. It then clears the shift register and the edge counter and enters ADDR.
- ADDR: on the 16th sample event it latches the address.
  - Flag = 1 → WDATA.
  - Flag = 0 → RREQ.
- WDATA: on the 16th sample event it latches the data and pulses `bus_wr` for one cycle → WWAIT.
- WWAIT: `bus_ack` → DONE.
- RREQ: pulses `bus_rd` for one cycle → RWAIT.
- RWAIT: on `bus_ack` it latches `bus_rdata` → RDATA.
- RDATA:
  - Asserts `spiclk_oe` and `dout_oe`.
  - Generates 16 clock periods: low for `DIV`, then high for `DIV`.
  - `dout` updates at the start of each low phase, MSB pair first.
  - After the 16th high phase it releases both enables → DONE.
- DONE: waits for `spiss` high → IDLE.

Timeout
- In WWAIT or RWAIT, a counter runs from entry. When it reaches `TIMEOUT` without `bus_ack`, `err` is set.
- WWAIT then goes to DONE.
- RWAIT loads `32'hDEAD_BEEF` and goes to RDATA.

Abort
- If the synchronised `spiss` goes high in ADDR or WDATA, the block returns to IDLE with no bus strobe.
- If it goes high in RDATA, the block releases the enables immediately and returns to IDLE.
- In WWAIT or RWAIT, the block first completes the wait (ack or timeout) and discards any read data, then returns to IDLE.
- A new `spiss` fall in DONE is ignored until `spiss` has been seen high.

## Timing

Reset values (`rst_n`=0 on a clock edge)
- State IDLE.
- `busy`, `err`, `bus_wr`, `bus_rd`, `spiclk_oe`, `dout_oe` = 0.
- `spiclk_out` = 0, `dout` = 0, `bus_addr` = 0, `bus_wdata` = 0.
- Reset mid-transaction abandons the transaction with no strobe and no bus traffic.

Latencies
- Input synchroniser latency is 2 cycles. Edge detection adds 1 cycle.
- The `bus_wr` pulse occurs 1 cycle after the internal detection of the 32nd write sample.
- `bus_rd` occurs 1 cycle after the 16th address sample.
- The first `spiclk_oe` occurs 1 cycle after `bus_ack` is sampled.
- `bus_addr` and `bus_wdata` are stable from their strobe until the next transaction.

Limits
- The host `spiclk` half-period must be ≥3 `clk` cycles.
- `bus_ack` in the same cycle as the strobe is legal.
- The edge counter is 4 bits and wraps after exactly 16 events; it is reset on entry to ADDR and to WDATA.

## Test plan

- Write command: `spiss` low, then 32 edges carrying `0xF800_0001` / `0x1234_5678`, with ack 3 cycles after the strobe → one `bus_wr` pulse, `bus_addr`=`0xF800_0000`, `bus_wdata`=`0x1234_5678`, no `bus_rd`, `err`=0.
- Read command: address `0xF800_0000`, with `bus_rdata`=`0xCAFE_0042` acked after 5 cycles → one `bus_rd` pulse, then 16 target clocks. `dout` pairs read back as `0xCAFE_0042` MSB first, and the enables drop after the last high phase.
- Read timeout: `bus_ack` held low → `err`=1 after 255 cycles, and 32'hDEAD_BEEF is returned over the link. `err` clears on the next `spiss` fall.
- Abort: `spiss` high after 10 address edges → no strobe, `busy`=0 within 4 cycles. A following full write then completes correctly.
- Reset mid-RDATA: `rst_n`=0 for one edge → all enables 0 and `busy`=0 on the next cycle, with no further `bus_rd`.
- Slow host: `spiclk` half-period of 3 `clk` cycles over a full write → data captured bit-exact.
